// File: rtl/demux_4_stream_if.sv
// Stream bundle for the 1:4 distributor: one producer-side input stream and four
// consumer lanes plus status. slave = distributor view, master = producer/consumer view.
interface demux_4_stream_if #(
  parameter int unsigned data_width = 16,
  parameter int unsigned cnt_width  = 8
) ();
  logic [data_width-1:0] din;
  logic [1:0]            sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] dout_0;
  logic [data_width-1:0] dout_1;
  logic [data_width-1:0] dout_2;
  logic [data_width-1:0] dout_3;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [3:0]            lane_full;
  logic [cnt_width-1:0]  words_out;

  modport slave (
    input  din, sel, in_valid, out_ready,
    output in_ready, dout_0, dout_1, dout_2, dout_3, out_valid, lane_full, words_out
  );

  modport master (
    output din, sel, in_valid, out_ready,
    input  in_ready, dout_0, dout_1, dout_2, dout_3, out_valid, lane_full, words_out
  );
endinterface

// File: rtl/demux_4_stream.sv
// Registered 1:4 stream distributor: din is routed by sel into one of four
// independent per-lane FIFOs; each lane drains on its own valid/ready handshake.
module demux_4_stream #(
  parameter int unsigned data_width = 16,
  parameter int unsigned depth      = 2,
  parameter int unsigned cnt_width  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  demux_4_stream_if.slave    bus
);
  localparam int unsigned aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);

  logic [data_width-1:0] mem [4][depth];
  logic [aw-1:0]         rd_ptr [4];
  logic [aw-1:0]         wr_ptr [4];
  logic [aw:0]           occ    [4];
  logic [cnt_width-1:0]  words_q;

  logic [3:0] full;
  logic [3:0] valid;
  logic [3:0] pop;
  logic [3:0] push_lane;
  logic       push;
  logic [2:0] pop_cnt;

  always_comb begin
    full      = '0;
    valid     = '0;
    pop       = '0;
    push_lane = '0;
    pop_cnt   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      full[k]  = (occ[k] == full_cnt);
      valid[k] = (occ[k] != '0);
    end
    // Refusal depends only on registered occupancy: no bypass when the lane pops.
    push = bus.in_valid && !full[bus.sel];
    for (int unsigned k = 0; k < 4; k++) begin
      pop[k]       = valid[k] && bus.out_ready[k];
      push_lane[k] = push && (bus.sel == 2'(k));
      pop_cnt      = pop_cnt + 3'(pop[k]);
    end
  end

  // Storage carries no reset; pointers and occupancy define what is live.
  always_ff @(posedge clk) begin
    if (push)
      mem[bus.sel][wr_ptr[bus.sel]] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < 4; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        occ[k]    <= '0;
      end
      words_q <= '0;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (push_lane[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])       rd_ptr[k] <= rd_ptr[k] + 1'b1;
        case ({push_lane[k], pop[k]})
          2'b10:   occ[k] <= occ[k] + 1'b1;
          2'b01:   occ[k] <= occ[k] - 1'b1;
          default: occ[k] <= occ[k];
        endcase
      end
      words_q <= words_q + cnt_width'(pop_cnt);
    end
  end

  assign bus.in_ready  = !full[bus.sel];
  assign bus.out_valid = valid;
  assign bus.lane_full = full;
  assign bus.words_out = words_q;
  assign bus.dout_0    = mem[0][rd_ptr[0]];
  assign bus.dout_1    = mem[1][rd_ptr[1]];
  assign bus.dout_2    = mem[2][rd_ptr[2]];
  assign bus.dout_3    = mem[3][rd_ptr[3]];
endmodule

// File: tb/tb_demux_4_stream.sv
// Directed bench for demux_4_stream: routing, per-lane backpressure, FIFO order,
// multi-lane pops, and reset discarding buffered words.
module tb_demux_4_stream;
  logic clk = 1'b0;
  logic reset_n;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  demux_4_stream_if #(.data_width(16), .cnt_width(8)) bus ();

  demux_4_stream #(.data_width(16), .depth(2), .cnt_width(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.din       = '0;
    bus.sel       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;

    // Reset then idle
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_lane_full", 32'(bus.lane_full), 32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
    chk("rst_words_out", 32'(bus.words_out), 32'h0);

    // Single route to lane 2
    bus.din = 16'hA5A5; bus.sel = 2'd2; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("route_out_valid", 32'(bus.out_valid), 32'h4);
    chk("route_dout_2",    32'(bus.dout_2),    32'hA5A5);
    bus.out_ready = 4'b0100;
    tick();
    bus.out_ready = 4'b0000;
    #1;
    chk("route_drained", 32'(bus.out_valid), 32'h0);
    chk("route_words",   32'(bus.words_out), 32'h1);

    // Fill lane 1, then try a third word
    bus.sel = 2'd1; bus.in_valid = 1'b1; bus.din = 16'h0001;
    tick();
    bus.din = 16'h0002;
    tick();
    bus.din = 16'h0003;
    #1;
    chk("fill_lane_full",  32'(bus.lane_full), 32'h2);
    chk("fill_in_ready_0", 32'(bus.in_ready),  32'h0);
    tick();
    chk("fill_still_full", 32'(bus.lane_full), 32'h2);
    chk("fill_head",       32'(bus.dout_1),    32'h0001);
    bus.sel = 2'd3; bus.din = 16'h0033;
    #1;
    chk("other_in_ready",  32'(bus.in_ready),  32'h1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("other_out_valid", 32'(bus.out_valid), 32'hA);
    chk("other_dout_3",    32'(bus.dout_3),    32'h0033);

    // Full lane with simultaneous pop: push must be refused
    bus.sel = 2'd1; bus.din = 16'h0099; bus.in_valid = 1'b1; bus.out_ready = 4'b0010;
    #1;
    chk("nobypass_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
    #1;
    chk("nobypass_dout_1",   32'(bus.dout_1),    32'h0002);
    chk("nobypass_full",     32'(bus.lane_full), 32'h0);
    chk("nobypass_in_ready", 32'(bus.in_ready),  32'h1);
    chk("nobypass_words",    32'(bus.words_out), 32'h2);
    bus.out_ready = 4'b1010;
    tick();
    bus.out_ready = 4'b0000;
    #1;
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_words",     32'(bus.words_out), 32'h4);

    // Streaming through lane 0 with the consumer always ready
    bus.sel = 2'd0; bus.in_valid = 1'b1; bus.out_ready = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      bus.din = 16'(16'h0010 + i);
      tick();
      chk("stream_valid", 32'(bus.out_valid[0]), 32'h1);
      chk("stream_dout",  32'(bus.dout_0),       32'(16'h0010 + i));
      chk("stream_full",  32'(bus.lane_full[0]), 32'h0);
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 4'b0000;
    #1;
    chk("stream_words", 32'(bus.words_out), 32'd12);
    chk("stream_empty", 32'(bus.out_valid), 32'h0);

    // One word in every lane, then pop all four at once
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.sel = 2'(k);
      bus.din = 16'(16'h0100 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("all_out_valid", 32'(bus.out_valid), 32'hF);
    chk("all_dout_0",    32'(bus.dout_0),    32'h0100);
    chk("all_dout_3",    32'(bus.dout_3),    32'h0103);
    bus.out_ready = 4'b1111;
    tick();
    bus.out_ready = 4'b0000;
    #1;
    chk("all_pop_words", 32'(bus.words_out), 32'd16);
    chk("all_pop_empty", 32'(bus.out_valid), 32'h0);

    // Refill, then reset with every consumer ready
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.sel = 2'(k);
      bus.din = 16'(16'h0200 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("refill_out_valid", 32'(bus.out_valid), 32'hF);
    reset_n = 1'b0; bus.out_ready = 4'b1111;
    tick();
    reset_n = 1'b1; bus.out_ready = 4'b0000;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_lane_full", 32'(bus.lane_full), 32'h0);
    chk("midrst_words",     32'(bus.words_out), 32'h0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
